// File: rtl/truth_table_sweeper_if.sv
// Bundle between the truth-table sweeper, its requester and the function block under test.
// The slave modport is the sweeper side.
interface truth_table_sweeper_if #(
  parameter int unsigned N_IN = 4
);
  localparam int unsigned T = 1 << N_IN;

  logic            start;
  logic [T-1:0]    expected;
  logic [N_IN-1:0] f_vec;
  logic            f_s;
  logic            busy;
  logic            done;
  logic [T-1:0]    table_out;
  logic [N_IN:0]   mismatch_cnt;
  logic [N_IN-1:0] first_err;
  logic            err_valid;
  logic            pass;

  modport master (
    output start, expected, f_s,
    input  f_vec, busy, done, table_out, mismatch_cnt, first_err, err_valid, pass
  );

  modport slave (
    input  start, expected, f_s,
    output f_vec, busy, done, table_out, mismatch_cnt, first_err, err_valid, pass
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks every input vector of an N_IN-input function, captures its output into a truth
// table and scores it against a golden table latched at start.
module truth_table_sweeper #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  truth_table_sweeper_if.slave bus
);
  localparam int unsigned T  = 1 << N_IN;
  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned MW = N_IN + 1;
  localparam logic [CW-1:0]   RELOAD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST   = N_IN'(T - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [T-1:0]  exp_q;
  logic          miss_c;
  logic [MW-1:0] cnt_inc_c;

  // Count including the vector being sampled, so the last vector feeds the pass decision.
  assign miss_c    = bus.f_s != exp_q[bus.f_vec];
  assign cnt_inc_c = bus.mismatch_cnt + MW'(miss_c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      exp_q            <= '0;
      bus.f_vec        <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.table_out    <= '0;
      bus.mismatch_cnt <= '0;
      bus.first_err    <= '0;
      bus.err_valid    <= 1'b0;
      bus.pass         <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state            <= RUN;
            bus.busy         <= 1'b1;
            exp_q            <= bus.expected;
            bus.f_vec        <= '0;
            wait_cnt         <= RELOAD;
            bus.table_out    <= '0;
            bus.mismatch_cnt <= '0;
            bus.first_err    <= '0;
            bus.err_valid    <= 1'b0;
            bus.pass         <= 1'b0;
          end
        end
        RUN: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CW'(1);
          end else begin
            bus.table_out[bus.f_vec] <= bus.f_s;
            if (miss_c) begin
              bus.mismatch_cnt <= cnt_inc_c;
              if (!bus.err_valid) begin
                bus.first_err <= bus.f_vec;
                bus.err_valid <= 1'b1;
              end
            end
            if (bus.f_vec == LAST) begin
              state     <= IDLE;
              bus.busy  <= 1'b0;
              bus.f_vec <= '0;
              bus.done  <= 1'b1;
              bus.pass  <= (cnt_inc_c == '0);
            end else begin
              bus.f_vec <= bus.f_vec + N_IN'(1);
              wait_cnt  <= RELOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE=1 and SETTLE=3) against a
// timeline model plus hand-computed end-of-sweep expectations.
module tb_truth_table_sweeper;
  localparam int unsigned T = 16;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_bad = 0;

  truth_table_sweeper_if #(.N_IN(4)) u0 ();
  truth_table_sweeper_if #(.N_IN(4)) u1 ();

  truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(u0));
  truth_table_sweeper #(.N_IN(4), .SETTLE(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(u1));

  // s = ~a&~b | b&~c&d | ~b&~c&~d with a = MSB of the vector
  function automatic logic gold(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (~a & ~b) | (b & ~c & d) | (~b & ~c & ~d);
  endfunction

  function automatic int settle_of(input int idx);
    return (idx == 0) ? 1 : 3;
  endfunction

  logic        start_d [2];
  logic [15:0] exp_d   [2];
  logic        busy_o  [2];
  logic        done_o  [2];
  logic [3:0]  fvec_o  [2];
  logic [15:0] tab_o   [2];
  logic [4:0]  cnt_o   [2];
  logic [3:0]  fe_o    [2];
  logic        ev_o    [2];
  logic        pass_o  [2];

  assign u0.start = start_d[0];
  assign u0.expected = exp_d[0];
  assign u0.f_s = gold(u0.f_vec);
  assign u1.start = start_d[1];
  assign u1.expected = exp_d[1];
  assign u1.f_s = gold(u1.f_vec);

  assign busy_o[0] = u0.busy;         assign busy_o[1] = u1.busy;
  assign done_o[0] = u0.done;         assign done_o[1] = u1.done;
  assign fvec_o[0] = u0.f_vec;        assign fvec_o[1] = u1.f_vec;
  assign tab_o[0]  = u0.table_out;    assign tab_o[1]  = u1.table_out;
  assign cnt_o[0]  = u0.mismatch_cnt; assign cnt_o[1]  = u1.mismatch_cnt;
  assign fe_o[0]   = u0.first_err;    assign fe_o[1]   = u1.first_err;
  assign ev_o[0]   = u0.err_valid;    assign ev_o[1]   = u1.err_valid;
  assign pass_o[0] = u0.pass;         assign pass_o[1] = u1.pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s inst%0d t=%0t got %0h want %0h", nm, idx, $time, got, want);
    end
  endtask

  // Model: a sweep is "edges since acceptance"; results follow from how many vectors have been sampled.
  logic        m_run  [2];
  int          m_k    [2];
  logic [15:0] m_exp  [2];
  logic        m_fin  [2];
  logic        m_done [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int idx = 0; idx < 2; idx++) begin
        m_run[idx] <= 1'b0; m_k[idx] <= 0; m_exp[idx] <= '0;
        m_fin[idx] <= 1'b0; m_done[idx] <= 1'b0;
      end
    end else begin
      for (int idx = 0; idx < 2; idx++) begin
        if (m_run[idx]) begin
          m_done[idx] <= (m_k[idx] + 1 == int'(T) * settle_of(idx));
          if (m_k[idx] + 1 == int'(T) * settle_of(idx)) begin
            m_run[idx] <= 1'b0; m_fin[idx] <= 1'b1; m_k[idx] <= 0;
          end else begin
            m_k[idx] <= m_k[idx] + 1;
          end
        end else begin
          m_done[idx] <= 1'b0;
          if (start_d[idx]) begin
            m_run[idx] <= 1'b1; m_k[idx] <= 0; m_exp[idx] <= exp_d[idx]; m_fin[idx] <= 1'b0;
          end
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    int n, cnt, fe;
    logic ev;
    logic [15:0] tb;
    for (int idx = 0; idx < 2; idx++) begin
      n = m_run[idx] ? m_k[idx] / settle_of(idx) : (m_fin[idx] ? int'(T) : 0);
      tb = '0; cnt = 0; fe = 0; ev = 1'b0;
      for (int i = 0; i < n; i++) begin
        tb[i] = gold(4'(i));
        if (gold(4'(i)) != m_exp[idx][i]) begin
          cnt++;
          if (!ev) begin fe = i; ev = 1'b1; end
        end
      end
      chk("busy", idx, 32'(busy_o[idx]), 32'(m_run[idx]));
      chk("done", idx, 32'(done_o[idx]), 32'(m_done[idx]));
      chk("f_vec", idx, 32'(fvec_o[idx]), m_run[idx] ? 32'(m_k[idx] / settle_of(idx)) : 32'd0);
      chk("table_out", idx, 32'(tab_o[idx]), 32'(tb));
      chk("mismatch_cnt", idx, 32'(cnt_o[idx]), 32'(cnt));
      chk("first_err", idx, 32'(fe_o[idx]), 32'(fe));
      chk("err_valid", idx, 32'(ev_o[idx]), 32'(ev));
      chk("pass", idx, 32'(pass_o[idx]), 32'(!m_run[idx] && m_fin[idx] && cnt == 0));
    end
  end

  // Called at a negedge: pulses start across the next posedge and returns one negedge later.
  task automatic launch(input int idx, input logic [15:0] e);
    start_d[idx] = 1'b1;
    exp_d[idx] = e;
    @(negedge clk);
    start_d[idx] = 1'b0;
  endtask

  task automatic wait_done(input int idx, inout int cyc);
    while (done_o[idx] !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", idx, 32'(done_o[idx]), 32'd1);
  endtask

  task automatic run_sweep(input int idx, input logic [15:0] e, output int cyc);
    launch(idx, e);
    cyc = 1;
    wait_done(idx, cyc);
  endtask

  task automatic chk_res(input string nm, input int idx, input logic [15:0] tab, input int cnt,
                         input int fe, input logic ev, input logic ps);
    chk({nm, "_table"}, idx, 32'(tab_o[idx]), 32'(tab));
    chk({nm, "_cnt"}, idx, 32'(cnt_o[idx]), 32'(cnt));
    chk({nm, "_first_err"}, idx, 32'(fe_o[idx]), 32'(fe));
    chk({nm, "_err_valid"}, idx, 32'(ev_o[idx]), 32'(ev));
    chk({nm, "_pass"}, idx, 32'(pass_o[idx]), 32'(ps));
  endtask

  initial begin
    int cyc;
    rst_n = 1'b1;
    start_d[0] = 1'b0; start_d[1] = 1'b0;
    exp_d[0] = '0; exp_d[1] = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 0, 32'(busy_o[0]), 32'd0);
    chk_res("reset", 0, 16'h0000, 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal, SETTLE=1
    run_sweep(0, 16'h212F, cyc);
    chk("nominal_latency", 0, 32'(cyc), 32'd17);
    chk_res("nominal", 0, 16'h212F, 0, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("done_one_cycle", 0, 32'(done_o[0]), 32'd0);

    run_sweep(0, 16'h212E, cyc);
    chk_res("single_err", 0, 16'h212F, 1, 0, 1'b1, 1'b0);

    run_sweep(0, 16'hDED0, cyc);
    chk_res("all_wrong", 0, 16'h212F, 16, 0, 1'b1, 1'b0);

    // Errors at vector 4 and at the final vector 15
    run_sweep(0, 16'hA13F, cyc);
    chk_res("last_vec_err", 0, 16'h212F, 2, 4, 1'b1, 1'b0);

    // SETTLE=3 instance
    run_sweep(1, 16'h212F, cyc);
    chk("settle3_latency", 1, 32'(cyc), 32'd49);
    chk_res("settle3", 1, 16'h212F, 0, 0, 1'b0, 1'b1);

    // Mid-sweep start and expected changes are ignored
    launch(0, 16'h212F);
    cyc = 1;
    repeat (4) begin @(negedge clk); cyc++; end
    start_d[0] = 1'b1;
    exp_d[0] = 16'h0000;
    @(negedge clk); cyc++;
    start_d[0] = 1'b0;
    exp_d[0] = 16'hFFFF;
    wait_done(0, cyc);
    chk("handshake_latency", 0, 32'(cyc), 32'd17);
    chk_res("handshake", 0, 16'h212F, 0, 0, 1'b0, 1'b1);

    // Start during the done cycle
    start_d[0] = 1'b1;
    exp_d[0] = 16'h2127;
    @(negedge clk);
    start_d[0] = 1'b0;
    chk("restart_busy", 0, 32'(busy_o[0]), 32'd1);
    chk("restart_done", 0, 32'(done_o[0]), 32'd0);
    chk_res("restart_clear", 0, 16'h0000, 0, 0, 1'b0, 1'b0);
    cyc = 1;
    wait_done(0, cyc);
    chk_res("restart", 0, 16'h212F, 1, 3, 1'b1, 1'b0);
    @(negedge clk);

    // Asynchronous reset mid-sweep
    launch(0, 16'hDED0);
    repeat (6) @(negedge clk);
    chk("pre_reset_busy", 0, 32'(busy_o[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_busy", 0, 32'(busy_o[0]), 32'd0);
    chk("async_f_vec", 0, 32'(fvec_o[0]), 32'd0);
    chk_res("async", 0, 16'h0000, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_done", 0, 32'(done_o[0]), 32'd0);
    run_sweep(0, 16'h212F, cyc);
    chk("post_reset_latency", 0, 32'(cyc), 32'd17);
    chk_res("post_reset", 0, 16'h212F, 0, 0, 1'b0, 1'b1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got timeout want completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Sequencer that exhaustively drives every input vector into an external N_IN-input combinational function block and samples its single output. It assembles the captured truth table and compares it bit-for-bit against a golden table. It reports mismatch count, first failing vector and pass/fail, with a start/busy/done handshake. It sits beside the function blocks as the on-chip self-check controller.

Parameters:
N_IN, 4, number of function inputs; table size T = 2^N_IN entries
SETTLE, 1, cycles each vector is held before sampling; legal range >= 1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  request a sweep; accepted only when idle (busy=0)
expected  input  T  golden table; bit i = required output for vector i; latched on the accepted start
f_vec  output  N_IN  vector driven to the function; MSB = first input (a), LSB = last (d)
f_s  input  1  function output for the current f_vec
busy  output  1  sweep in progress
done  output  1  one-cycle completion pulse
table_out  output  T  captured table; bit i = f_s sampled for vector i
mismatch_cnt  output  N_IN+1  number of entries where table_out differs from expected
first_err  output  N_IN  lowest mismatching vector index
err_valid  output  1  at least one mismatch seen; qualifies first_err
pass  output  1  sweep finished with mismatch_cnt == 0

Behaviour:
- All outputs are registered.
- Reset (rst_n=0) is asynchronous and takes effect immediately: FSM=IDLE; f_vec=0; busy=0; done=0; table_out=0; mismatch_cnt=0; first_err=0; err_valid=0; pass=0; internal wait counter=0; latched expected=0.
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE, start=1 at edge E0:
  - next state RUN
  - latch expected
  - f_vec<=0; wait counter<=SETTLE-1
  - clear table_out, mismatch_cnt, first_err, err_valid, pass
- RUN, each edge:
  - If counter != 0: decrement the counter.
  - Otherwise it is a sample edge: table_out[f_vec]<=f_s.
    - If f_s != expected_q[f_vec]: mismatch_cnt++. If err_valid is 0, also first_err<=f_vec and err_valid<=1.
    - If f_vec == T-1: state<=IDLE, f_vec<=0, done<=1, pass<=(final mismatch count == 0).
    - Otherwise: f_vec++ and counter<=SETTLE-1.
- Timing:
  - Vector i is sampled at edge E0+(i+1)*SETTLE.
  - busy is high from E0 through the last sample edge E0+T*SETTLE.
  - done is high for exactly the one cycle after that edge. done and busy are never both 1.
- The pass decision includes any mismatch on the final vector; the compare and count update happen in the same edge.
- start while busy=1 is ignored; expected changes while busy have no effect.
- start during the done cycle is accepted (the FSM is IDLE): a new sweep begins and clears results at that edge. done still drops after one cycle.
- Results (table_out, mismatch_cnt, first_err, err_valid, pass) hold their values after done until the next accepted start.
- mismatch_cnt is N_IN+1 bits wide, so it holds T exactly (all entries wrong) without wrap.
- f_vec is a plain binary up-count 0..T-1 with no wrap during RUN. It returns to 0 at completion.
- Reset mid-sweep: everything returns to reset values and no done pulse is generated. A later start runs a full fresh sweep.

Test Plan:
- Nominal sweep: N_IN=4, SETTLE=1, bench function s = ~a&~b | b&~c&d | ~b&~c&~d, expected=16'h212F, start pulse at E0 -> f_vec steps 0..15, busy high E0..E0+16, done at the cycle after E0+16, table_out=16'h212F, mismatch_cnt=0, err_valid=0, pass=1.
- Single error: same function, expected=16'h212E -> mismatch_cnt=1, first_err=0, err_valid=1, pass=0, table_out=16'h212F.
- All wrong: expected=16'hDED0 -> mismatch_cnt=16 (5'b10000, no wrap), first_err=0, pass=0.
- Settle timing: SETTLE=3, expected=16'h212F -> each f_vec value held 3 cycles, vector i sampled at E0+3(i+1), done one cycle after E0+48, pass=1.
- Handshake: pulse start at E0+5 mid-sweep, then toggle expected mid-sweep -> both ignored and results unchanged. A start in the done cycle launches a new sweep: results clear at that edge, busy=1 on the next cycle.
- Reset mid-sweep: drop rst_n asynchronously at E0+7 -> all outputs 0 immediately with no done pulse. After release, start with expected=16'h212F -> full sweep, pass=1.
